// File: rtl/rca_chain_ctrl.sv
// Wide adder sequencer driving one external 8-bit ripple-carry adder, LSB slice first.
// Define RCA_CHAIN_SUB_EN to add the sub port for two's-complement subtraction.
module rca_chain_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   op_a,
    input  logic [8*NBYTES-1:0]   op_b,
    input  logic                  cin,
`ifdef RCA_CHAIN_SUB_EN
    input  logic                  sub,
`endif
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   result,
    output logic                  cout,
    output logic [7:0]            rca_a,
    output logic [7:0]            rca_b,
    output logic                  rca_cin,
    input  logic [7:0]            rca_sum,
    input  logic                  rca_cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            sub_mode;
    logic [7:0]      a_sl;
    logic [7:0]      b_sl;

`ifdef RCA_CHAIN_SUB_EN
    logic            sub_q, sub_d;
    assign sub_mode = sub_q;
`else
    assign sub_mode = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef RCA_CHAIN_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            result_q <= result_d;
            cout_q   <= cout_d;
`ifdef RCA_CHAIN_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

    // Slice mux is driven only from registers, so no loop exists through the adder.
    always_comb begin
        a_sl = 8'h00;
        b_sl = 8'h00;
        for (int i = 0; i < NBYTES; i++) begin
            if (idx_q == IW'(i)) begin
                a_sl = a_q[8*i +: 8];
                b_sl = b_q[8*i +: 8];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        result_d = result_q;
        cout_d   = cout_q;
`ifdef RCA_CHAIN_SUB_EN
        sub_d    = sub_q;
`endif
        rca_a    = 8'h00;
        rca_b    = 8'h00;
        rca_cin  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    idx_d   = '0;
                    state_d = RUN;
`ifdef RCA_CHAIN_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end
            RUN: begin
                rca_a   = a_sl;
                rca_b   = b_sl ^ {8{sub_mode}};
                rca_cin = carry_q;
                for (int i = 0; i < NBYTES; i++) begin
                    if (idx_q == IW'(i)) begin
                        result_d[8*i +: 8] = rca_sum;
                    end
                end
                carry_d = rca_cout;
                if (idx_q == IW'(NBYTES - 1)) begin
                    cout_d  = rca_cout;
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy   = (state_q == RUN);
    assign done   = (state_q == DONE);
    assign result = result_q;
    assign cout   = cout_q;

endmodule
